// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one external memory port between instruction fetch (requester 0,
//   read-only) and the data port (requester 1, read/write). One requester is
//   granted at a time. The memory port is driven only from registered copies
//   of the owner's address, write data and write enable. Each access holds
//   the port for MEM_LATENCY cycles and then issues a one-cycle ready pulse
//   to the owner.
//
//   Build option:
//     MEM_ARB_RR_EN  When defined, two simultaneous requests alternate
//                    between the requesters using a last_owner bit.
//                    When undefined, the data port always wins a tie.
//
//   Ports:
//     clk, rst_async                   clock, async active-high reset
//     if_req, if_addr                  fetch request and address
//     if_ready, if_rdata               fetch completion pulse and read data
//     d_req, d_we, d_addr, d_wdata     data request, store flag, address, data
//     d_ready, d_rdata                 data completion pulse and load data
//     mem_active, mem_we               memory access strobe and write enable
//     mem_addr, mem_wdata, mem_rdata   memory address, write and read data
//     busy                             arbiter is not idle
//
//   state  | meaning
//   IDLE   | no access in flight; waiting to grant a requester
//   ACCESS | memory port driven from the latched request; cnt counts down
//   DONE   | owner's ready pulse; requests ignored, returns to IDLE

module mem_arbiter #(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst_async,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_active,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
    $fatal(1, "mem_arbiter: MEM_LATENCY must be 1..15");
  end

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        cnt;
  logic              owner_q;   // 1 = data port, 0 = fetch
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              any_req;
  logic              grant_d;

`ifdef MEM_ARB_RR_EN
  logic last_owner;   // 1 = data port was granted last

  // On a tie the requester that did not win last time is granted.
  assign grant_d = d_req && (!if_req || !last_owner);
`else
  assign grant_d = d_req;
`endif

  assign any_req = if_req || d_req;

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes decode from the async-reset state so they drop with reset.
  always_comb begin
    mem_active = 1'b0;
    mem_we     = 1'b0;
    if_ready   = 1'b0;
    d_ready    = 1'b0;
    busy       = (state != IDLE);
    case (state)
      ACCESS: begin
        mem_active = 1'b1;
        mem_we     = we_q;
      end
      DONE: begin
        if_ready = !owner_q;
        d_ready  = owner_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      cnt      <= 4'd0;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
`ifdef MEM_ARB_RR_EN
      last_owner <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner_q <= grant_d;
            we_q    <= grant_d && d_we;
            addr_q  <= grant_d ? d_addr : if_addr;
            wdata_q <= grant_d ? d_wdata : '0;
            cnt     <= CNT_INIT;
`ifdef MEM_ARB_RR_EN
            last_owner <= grant_d;
`endif
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (!we_q) begin
            if (owner_q) d_rdata  <= mem_rdata;
            else         if_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Four instances with MEM_LATENCY 1..4 share
// the same stimulus; each scenario checks the instance whose latency it needs.
module tb_mem_arbiter;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst_async;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              if_ready_a   [4];
  logic [DATA_W-1:0] if_rdata_a   [4];
  logic              d_ready_a    [4];
  logic [DATA_W-1:0] d_rdata_a    [4];
  logic              mem_active_a [4];
  logic              mem_we_a     [4];
  logic [ADDR_W-1:0] mem_addr_a   [4];
  logic [DATA_W-1:0] mem_wdata_a  [4];
  logic              busy_a       [4];

  int n_vec = 0;
  int n_err = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mem_arbiter #(
      .MEM_LATENCY(g + 1),
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W)
    ) u_dut (
      .clk       (clk),
      .rst_async (rst_async),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_ready  (if_ready_a[g]),
      .if_rdata  (if_rdata_a[g]),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_ready   (d_ready_a[g]),
      .d_rdata   (d_rdata_a[g]),
      .mem_active(mem_active_a[g]),
      .mem_we    (mem_we_a[g]),
      .mem_addr  (mem_addr_a[g]),
      .mem_wdata (mem_wdata_a[g]),
      .mem_rdata (mem_rdata),
      .busy      (busy_a[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_async = 1'b1;
    if_req    = 1'b0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_async = 1'b0;
  endtask

  initial begin
    logic exp_d;
    int   seen;

    rst_async = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_rdata = '0;

    // Reset state
    do_reset();
    for (int k = 0; k < 4; k += 3) begin
      check_vec("rst_busy",     64'(busy_a[k]),       64'(0));
      check_vec("rst_active",   64'(mem_active_a[k]), 64'(0));
      check_vec("rst_if_rdata", 64'(if_rdata_a[k]),   64'(0));
      check_vec("rst_d_rdata",  64'(d_rdata_a[k]),    64'(0));
      check_vec("rst_mem_addr", 64'(mem_addr_a[k]),   64'(0));
    end

    // Fetch read, latency 1
    if_req    = 1'b1;
    if_addr   = 20'h00010;
    mem_rdata = 32'hDEADBEEF;
    tick();
    check_vec("f1_active", 64'(mem_active_a[0]), 64'(1));
    check_vec("f1_addr",   64'(mem_addr_a[0]),   64'(20'h00010));
    check_vec("f1_we",     64'(mem_we_a[0]),     64'(0));
    check_vec("f1_busy",   64'(busy_a[0]),       64'(1));
    check_vec("f1_nordy",  64'(if_ready_a[0]),   64'(0));
    tick();
    check_vec("f1_ready",  64'(if_ready_a[0]),   64'(1));
    check_vec("f1_rdata",  64'(if_rdata_a[0]),   64'(32'hDEADBEEF));
    check_vec("f1_idle_m", 64'(mem_active_a[0]), 64'(0));
    check_vec("f1_busy2",  64'(busy_a[0]),       64'(1));
    if_req = 1'b0;
    tick();
    check_vec("f1_busy_off", 64'(busy_a[0]),     64'(0));
    check_vec("f1_rdy_off",  64'(if_ready_a[0]), 64'(0));

    // Data store, latency 3
    do_reset();
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 20'h0ABCD;
    d_wdata = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_vec("st_we",    64'(mem_we_a[2]),    64'(1));
      check_vec("st_addr",  64'(mem_addr_a[2]),  64'(20'h0ABCD));
      check_vec("st_wdata", 64'(mem_wdata_a[2]), 64'(32'h12345678));
    end
    tick();
    check_vec("st_ready",  64'(d_ready_a[2]), 64'(1));
    check_vec("st_rdata",  64'(d_rdata_a[2]), 64'(0));
    check_vec("st_we_off", 64'(mem_we_a[2]),  64'(0));
    d_req = 1'b0;
    d_we  = 1'b0;
    tick();
    check_vec("st_idle", 64'(busy_a[2]), 64'(0));

    // Simultaneous requests, latency 1: DONE lands every third cycle
    do_reset();
    if_req    = 1'b1;
    if_addr   = 20'h00111;
    d_req     = 1'b1;
    d_we      = 1'b0;
    d_addr    = 20'h00222;
    mem_rdata = 32'h0BADF00D;
    for (int j = 0; j < 3; j++) begin
`ifdef MEM_ARB_RR_EN
      exp_d = (j % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      tick();
      check_vec("both_addr", 64'(mem_addr_a[0]), exp_d ? 64'(20'h00222) : 64'(20'h00111));
      tick();
      check_vec("both_d_rdy",  64'(d_ready_a[0]),  64'(exp_d));
      check_vec("both_if_rdy", 64'(if_ready_a[0]), 64'(!exp_d));
      tick();
    end
`ifndef MEM_ARB_RR_EN
    check_vec("both_if_starved", 64'(if_rdata_a[0]), 64'(0));
`endif
    if_req = 1'b0;
    d_req  = 1'b0;

    // Input churn during ACCESS, latency 4
    do_reset();
    d_req     = 1'b1;
    d_we      = 1'b0;
    d_addr    = 20'h00004;
    mem_rdata = 32'hCAFE0001;
    tick();
    check_vec("churn_a1", 64'(mem_addr_a[3]), 64'(20'h00004));
    d_addr = 20'h00008;
    tick();
    check_vec("churn_a2", 64'(mem_addr_a[3]), 64'(20'h00004));
    d_req = 1'b0;
    tick();
    check_vec("churn_a3", 64'(mem_addr_a[3]), 64'(20'h00004));
    tick();
    check_vec("churn_act", 64'(mem_active_a[3]), 64'(1));
    tick();
    check_vec("churn_ready", 64'(d_ready_a[3]), 64'(1));
    check_vec("churn_rdata", 64'(d_rdata_a[3]), 64'(32'hCAFE0001));

    // Reset during the second ACCESS cycle, latency 4
    do_reset();
    if_req  = 1'b1;
    if_addr = 20'h00020;
    tick();
    tick();
    check_vec("rm_active_pre", 64'(mem_active_a[3]), 64'(1));
    rst_async = 1'b1;
    if_req    = 1'b0;
    #1;
    check_vec("rm_active", 64'(mem_active_a[3]), 64'(0));
    check_vec("rm_busy",   64'(busy_a[3]),       64'(0));
    check_vec("rm_rdy",    64'(if_ready_a[3]),   64'(0));
    for (int i = 0; i < 2; i++) begin
      tick();
      check_vec("rm_no_rdy", 64'(if_ready_a[3]), 64'(0));
    end
    rst_async = 1'b0;
    if_req    = 1'b1;
    if_addr   = 20'h00030;
    mem_rdata = 32'h55AA55AA;
    seen = -1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (if_ready_a[3] && seen < 0) begin
        seen   = t;
        if_req = 1'b0;
        check_vec("rm_rdata", 64'(if_rdata_a[3]), 64'(32'h55AA55AA));
      end
    end
    check_vec("rm_latency", 64'(seen), 64'(5));

    // Back-to-back loads, latency 2: ready at ticks 3 and 7
    do_reset();
    d_req     = 1'b1;
    d_we      = 1'b0;
    d_addr    = 20'h00100;
    mem_rdata = 32'h11111111;
    for (int t = 1; t <= 7; t++) begin
      tick();
      check_vec("b2b_ready", 64'(d_ready_a[1]), 64'((t == 3) || (t == 7)));
      if (t == 3) begin
        check_vec("b2b_rdata1", 64'(d_rdata_a[1]), 64'(32'h11111111));
        mem_rdata = 32'h22222222;
      end
      if (t == 7) begin
        check_vec("b2b_rdata2", 64'(d_rdata_a[1]), 64'(32'h22222222));
        d_req = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single external memory port between two requesters.
- Requester 0 is instruction fetch (read-only). Requester 1 is the data port driven by the memory-access stage (read/write).
- Grants one requester at a time and drives the memory port from registered copies of that requester's address, write data and write enable.
- Waits a fixed MEM_LATENCY cycles per access, then returns read data and a one-cycle ready pulse to the owner.

Parameters:
- MEM_LATENCY, 1, cycles the memory port holds each access; legal values are 1 to 15.
- ADDR_W, 20, memory address width.
- DATA_W, 32, memory data width.

Ports:
- clk  in  1  clock
- rst_async  in  1  asynchronous active-high reset
- if_req  in  1  fetch requests a read; held with if_addr until if_ready
- if_addr  in  ADDR_W  fetch address
- if_ready  out  1  one-cycle pulse: fetch access complete, if_rdata valid
- if_rdata  out  DATA_W  fetch read data, registered
- d_req  in  1  data port requests an access; held with d_we/d_addr/d_wdata until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ready  out  1  one-cycle pulse: data access complete
- d_rdata  out  DATA_W  load data, registered
- mem_active  out  1  memory access in progress
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid in the final ACCESS cycle
- busy  out  1  state is not IDLE

Behaviour:
- Reset (asynchronous, rst_async high):
  - state = IDLE and the counter clears.
  - All outputs are 0, including the rdata registers.
  - mem_active and mem_we drop in the same instant. An in-flight access is abandoned and no ready pulse is issued.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If any request is asserted, select an owner, latch its address, write data and we (fetch latches we = 0), load cnt = MEM_LATENCY-1, and go to ACCESS.
  - Priority: d_req beats if_req.
  - With neither request asserted, stay in IDLE.
- ACCESS:
  - mem_active = 1; mem_addr, mem_wdata and mem_we come from the latched registers only, never from live inputs.
  - If cnt != 0, decrement it.
  - If cnt == 0 and the access is a read, load the owner's rdata register from mem_rdata, then go to DONE.
  - If cnt == 0 and the access is a write, go to DONE; d_rdata keeps its previous value.
- DONE:
  - Owner's ready = 1 for exactly this cycle; mem_active = 0.
  - Requests are ignored in this cycle; the next state is always IDLE.
- Latency: grant at edge N; the ACCESS cycles are N+1 through N+MEM_LATENCY; ready is high in cycle N+MEM_LATENCY+1.
- Throughput: back-to-back accesses start one every MEM_LATENCY+2 cycles.
- Request dropped mid-access: the access still completes and ready still pulses.
- Requester inputs changing during ACCESS have no effect on the memory port.
- rdata registers hold their value until the next read for that requester completes.
- Counter width is 4 bits.
- An out-of-range MEM_LATENCY is a fatal elaboration error.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined:
  - A 1-bit last_owner register (reset 0 = fetch) is updated at each grant.
  - When both requests are asserted in IDLE, the requester that is not last_owner wins.
  - A single requester is granted as normal.
- Undefined: fixed priority, data over fetch; last_owner does not exist.

Test Plan:
- Fetch read, MEM_LATENCY=1: if_req=1, if_addr=0x00010, mem_rdata=0xDEADBEEF.
  - Required: mem_active=1 for 1 cycle with mem_addr=0x00010 and mem_we=0.
  - Then if_ready pulses for 1 cycle with if_rdata=0xDEADBEEF; busy is high for 2 cycles.
- Data store, MEM_LATENCY=3: d_req=1, d_we=1, d_addr=0x0ABCD, d_wdata=0x12345678.
  - Required: mem_we=1 for 3 cycles with stable address and data.
  - Then d_ready pulses; d_rdata is unchanged (0 after reset).
- Simultaneous requests, macro off: if_req=1 and d_req=1 held continuously.
  - Required: the data port is granted on every IDLE cycle and fetch never completes.
  - With MEM_ARB_RR_EN the grants alternate data, fetch, data; data goes first because last_owner resets to fetch.
- Input churn: change d_addr from 0x00004 to 0x00008 mid-ACCESS, then drop d_req.
  - Required: mem_addr stays 0x00004 and d_ready still pulses.
- Reset mid-access, MEM_LATENCY=4: assert rst_async during the 2nd ACCESS cycle.
  - Required: mem_active=0 immediately, no ready pulse, busy=0.
  - After release, a new if_req is serviced normally.
- Back-to-back loads, MEM_LATENCY=2: d_req held with d_we=0 for two transactions.
  - Required: ready pulses are 4 cycles apart and d_rdata updates on each pulse.
